// File: rtl/video_sink_pkg.sv
// Shared types for the video stream sink: FSM states, packet type codes,
// FIFO word layout and the sop classification helper.
package video_sink_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CTRL  = 2'd1,
    VIDEO = 2'd2,
    SKIP  = 2'd3
  } sink_state_t;

  localparam logic [3:0] PKT_VIDEO = 4'h0;
  localparam logic [3:0] PKT_CTRL  = 4'hF;

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [31:0] data;
  } fifo_word_t;

  // State entered after popping a sop word; a single-word packet is already complete.
  function automatic sink_state_t classify_sop(input fifo_word_t w);
    if (w.eop)                         return IDLE;
    else if (w.data[3:0] == PKT_VIDEO) return VIDEO;
    else if (w.data[3:0] == PKT_CTRL)  return CTRL;
    else                               return SKIP;
  endfunction

endpackage

// File: rtl/video_sink_fifo.sv
// Synchronous input FIFO for the video sink. Head word is presented
// combinationally; writes while full are dropped by the FIFO itself.
module video_sink_fifo
  import video_sink_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_wr_en,
  input  fifo_word_t               i_wr_word,
  input  logic                     i_rd_en,
  output fifo_word_t               o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty,
  output logic                     o_full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  fifo_word_t      r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic            w_wr;
  logic            w_rd;

  assign o_full  = (r_count == CNT_FULL);
  assign o_empty = (r_count == '0);
  assign w_wr    = i_wr_en && !o_full;
  assign w_rd    = i_rd_en && !o_empty;
  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // Storage array, written at the write pointer.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_word;
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/video_stream_sink.sv
// Avalon-ST video sink feeding the framebuffer writer. Drops control and
// unknown packets, tags video pixels with x/y, flags short/long frames and
// input overflow. Define VIDEO_SINK_STATUS_EN to add frame_cnt/ctrl_cnt.
//
// state | meaning
// IDLE  | waiting for a sop; non-sop words are discarded
// CTRL  | inside a control packet, discarding until eop
// VIDEO | inside a video packet, forwarding pixels with coordinates
// SKIP  | inside an unknown or oversized packet, discarding until eop
module video_stream_sink
  import video_sink_pkg::*;
#(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 90,
  parameter int DEPTH  = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [31:0]                 in_data,
  input  logic                        in_sop,
  input  logic                        in_eop,
  output logic                        pix_valid,
  input  logic                        pix_ready,
  output logic [23:0]                 pix_data,
  output logic [$clog2(WIDTH)-1:0]    pix_x,
  output logic [$clog2(HEIGHT)-1:0]   pix_y,
  output logic                        pix_sof,
  output logic                        pix_eol,
  output logic                        err_short,
  output logic                        err_long,
  output logic                        err_ovf
`ifdef VIDEO_SINK_STATUS_EN
  ,
  output logic [15:0]                 frame_cnt,
  output logic [15:0]                 ctrl_cnt
`endif
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [XW-1:0] X_LAST      = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST      = YW'(HEIGHT - 1);
  localparam logic [CW-1:0] CNT_RDY_MAX = CW'(DEPTH - 2);

  fifo_word_t    w_wr_word;
  fifo_word_t    w_head;
  logic [CW-1:0] w_count;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_out_free;
  logic          w_load;
  logic          w_last;
  logic [3:0]    w_type;

  sink_state_t   r_state;
  sink_state_t   w_state_nxt;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic          r_done;
  logic [XW-1:0] w_x_nxt;
  logic [YW-1:0] w_y_nxt;
  logic          w_done_nxt;
  logic          w_err_short;
  logic          w_err_long;
  logic          w_frame_good;
  logic          w_ctrl_seen;

  logic          r_pix_valid;
  logic [23:0]   r_pix_data;
  logic [XW-1:0] r_pix_x;
  logic [YW-1:0] r_pix_y;
  logic          r_pix_sof;
  logic          r_pix_eol;
  logic          r_err_short;
  logic          r_err_long;
  logic          r_err_ovf;
  logic          w_unused_hi;

  assign w_wr_word  = '{sop: in_sop, eop: in_eop, data: in_data};
  assign in_ready   = !reset && (w_count <= CNT_RDY_MAX);
  assign w_out_free = !r_pix_valid || pix_ready;
  assign w_type     = w_head.data[3:0];
  assign w_last     = (r_x == X_LAST) && (r_y == Y_LAST);
  assign w_unused_hi = ^w_head.data[31:24];

  video_sink_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (in_valid),
    .i_wr_word (w_wr_word),
    .i_rd_en   (w_pop),
    .o_head    (w_head),
    .o_count   (w_count),
    .o_empty   (w_empty),
    .o_full    (w_full)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state, pop decision, coordinate update and error events.
  always_comb begin
    w_state_nxt  = r_state;
    w_pop        = 1'b0;
    w_load       = 1'b0;
    w_x_nxt      = r_x;
    w_y_nxt      = r_y;
    w_done_nxt   = r_done;
    w_err_short  = 1'b0;
    w_err_long   = 1'b0;
    w_frame_good = 1'b0;
    w_ctrl_seen  = 1'b0;
    case (r_state)
      IDLE: begin
        w_pop = !w_empty;
        if (w_pop && w_head.sop) begin
          w_state_nxt = classify_sop(w_head);
          w_ctrl_seen = (w_type == PKT_CTRL);
          w_x_nxt     = '0;
          w_y_nxt     = '0;
          w_done_nxt  = 1'b0;
        end
      end
      CTRL, SKIP: begin
        w_pop = !w_empty;
        if (w_pop && w_head.eop) w_state_nxt = IDLE;
      end
      VIDEO: begin
        // Pops wait for the output register so a held pixel is never overwritten.
        w_pop = !w_empty && w_out_free;
        if (w_pop) begin
          if (w_head.sop) begin
            w_err_short = !r_done;
            w_state_nxt = classify_sop(w_head);
            w_ctrl_seen = (w_type == PKT_CTRL);
            w_x_nxt     = '0;
            w_y_nxt     = '0;
            w_done_nxt  = 1'b0;
          end else if (r_done) begin
            w_err_long  = 1'b1;
            w_state_nxt = w_head.eop ? IDLE : SKIP;
            w_done_nxt  = 1'b0;
          end else begin
            w_load = 1'b1;
            if (w_last) begin
              w_x_nxt = '0;
              w_y_nxt = '0;
              if (w_head.eop) begin
                w_state_nxt  = IDLE;
                w_frame_good = 1'b1;
              end else begin
                w_done_nxt = 1'b1;
              end
            end else if (w_head.eop) begin
              w_err_short = 1'b1;
              w_state_nxt = IDLE;
              w_x_nxt     = '0;
              w_y_nxt     = '0;
            end else if (r_x == X_LAST) begin
              w_x_nxt = '0;
              w_y_nxt = r_y + 1'b1;
            end else begin
              w_x_nxt = r_x + 1'b1;
            end
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Frame position tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x    <= '0;
      r_y    <= '0;
      r_done <= 1'b0;
    end else begin
      r_x    <= w_x_nxt;
      r_y    <= w_y_nxt;
      r_done <= w_done_nxt;
    end
  end

  // Output pixel register: load on pop, otherwise drain when accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pix_valid <= 1'b0;
      r_pix_data  <= '0;
      r_pix_x     <= '0;
      r_pix_y     <= '0;
      r_pix_sof   <= 1'b0;
      r_pix_eol   <= 1'b0;
    end else if (w_load) begin
      r_pix_valid <= 1'b1;
      r_pix_data  <= w_head.data[23:0];
      r_pix_x     <= r_x;
      r_pix_y     <= r_y;
      r_pix_sof   <= (r_x == '0) && (r_y == '0);
      r_pix_eol   <= (r_x == X_LAST);
    end else if (pix_ready) begin
      r_pix_valid <= 1'b0;
    end
  end

  // Error pulses and sticky overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_short <= 1'b0;
      r_err_long  <= 1'b0;
      r_err_ovf   <= 1'b0;
    end else begin
      r_err_short <= w_err_short;
      r_err_long  <= w_err_long;
      r_err_ovf   <= r_err_ovf | (in_valid & w_full);
    end
  end

  assign pix_valid = r_pix_valid;
  assign pix_data  = r_pix_data;
  assign pix_x     = r_pix_x;
  assign pix_y     = r_pix_y;
  assign pix_sof   = r_pix_sof;
  assign pix_eol   = r_pix_eol;
  assign err_short = r_err_short;
  assign err_long  = r_err_long;
  assign err_ovf   = r_err_ovf;

`ifdef VIDEO_SINK_STATUS_EN
  logic [15:0] r_frame_cnt;
  logic [15:0] r_ctrl_cnt;

  // Good-frame and control-packet counters, both free-running and wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frame_cnt <= '0;
      r_ctrl_cnt  <= '0;
    end else begin
      if (w_frame_good) r_frame_cnt <= r_frame_cnt + 1'b1;
      if (w_ctrl_seen)  r_ctrl_cnt  <= r_ctrl_cnt + 1'b1;
    end
  end

  assign frame_cnt = r_frame_cnt;
  assign ctrl_cnt  = r_ctrl_cnt;
`else
  logic w_unused_status;
  assign w_unused_status = w_frame_good | w_ctrl_seen;
`endif

endmodule

// File: tb/tb_video_stream_sink.sv
// Directed bench for video_stream_sink using a reduced 12x5 frame.
module tb_video_stream_sink;

  localparam int W    = 12;
  localparam int H    = 5;
  localparam int D    = 8;
  localparam int NPIX = W * H;
  localparam int XW   = $clog2(W);
  localparam int YW   = $clog2(H);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   in_data = '0;
  logic          in_sop = 1'b0;
  logic          in_eop = 1'b0;
  logic          pix_valid;
  logic          pix_ready = 1'b0;
  logic [23:0]   pix_data;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic          pix_sof;
  logic          pix_eol;
  logic          err_short;
  logic          err_long;
  logic          err_ovf;
`ifdef VIDEO_SINK_STATUS_EN
  logic [15:0]   frame_cnt;
  logic [15:0]   ctrl_cnt;
`endif

  typedef struct packed {
    logic [23:0]   d;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          sof;
    logic          eol;
  } cap_t;

  logic [33:0] words[$];
  cap_t        cap[$];
  int n_checks = 0;
  int n_errors = 0;
  int widx, n_short, n_long, hold_bad;
  int rdy_div = 1;
  int up_on = 1;
  int up_off = 0;

  always #5 clk = ~clk;

  video_stream_sink #(.WIDTH(W), .HEIGHT(H), .DEPTH(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sop    (in_sop),
    .in_eop    (in_eop),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_data  (pix_data),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_sof   (pix_sof),
    .pix_eol   (pix_eol),
    .err_short (err_short),
    .err_long  (err_long),
    .err_ovf   (err_ovf)
`ifdef VIDEO_SINK_STATUS_EN
    ,
    .frame_cnt (frame_cnt),
    .ctrl_cnt  (ctrl_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic add_word(input logic sop, input logic eop, input logic [31:0] data);
    words.push_back({sop, eop, data});
  endtask

  // Video packet: type-0 sop then npix pixels {0,seed,k}, eop on the last.
  task automatic add_frame(input logic [7:0] seed, input int npix);
    add_word(1'b1, 1'b0, {24'h0, seed[3:0], 4'h0});
    for (int k = 0; k < npix; k++)
      add_word(1'b0, k == npix - 1, {8'h00, seed, 16'(k)});
  endtask

  task automatic start_test();
    words.delete();
    cap.delete();
    widx = 0; n_short = 0; n_long = 0; hold_bad = 0;
  endtask

  function automatic int frame_bad(input int base, input int n, input logic [7:0] seed);
    int bad = 0;
    for (int k = 0; k < n; k++) begin
      if (base + k >= cap.size()) bad++;
      else if (cap[base+k].d !== {seed, 16'(k)} || cap[base+k].x !== XW'(k % W) ||
               cap[base+k].y !== YW'(k / W) || cap[base+k].sof !== (k == 0) ||
               cap[base+k].eol !== ((k % W) == W - 1)) bad++;
    end
    return bad;
  endfunction

  function automatic int eol_count();
    int c = 0;
    foreach (cap[i]) if (cap[i].eol) c++;
    return c;
  endfunction

  // Streams words[] honouring in_ready, captures accepted pixels, counts error pulses.
  task automatic run_stream(input int stop_pix);
    int   cyc = 0;
    int   idle = 0;
    bit   prev_stall = 0;
    cap_t held = '0;
    cap_t now;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (in_valid) widx++;
      pix_ready = (rdy_div <= 1) ? 1'b1 : ((cyc % rdy_div) == 0);
      now = '{d: pix_data, x: pix_x, y: pix_y, sof: pix_sof, eol: pix_eol};
      if (prev_stall && now !== held) hold_bad++;
      if (pix_valid && pix_ready) cap.push_back(now);
      prev_stall = pix_valid && !pix_ready;
      held = now;
      if (err_short) n_short++;
      if (err_long) n_long++;
      if (widx < words.size() && in_ready && ((cyc % (up_on + up_off)) < up_on)) begin
        in_valid = 1'b1;
        {in_sop, in_eop, in_data} = words[widx];
      end else begin
        in_valid = 1'b0;
      end
      if (stop_pix >= 0 && cap.size() >= stop_pix) break;
      if (widx >= words.size() && !in_valid) idle++;
      if (idle >= 60) break;
      if (cyc >= 3000) begin
        chk("timeout_words_sent", widx, words.size());
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic do_reset_checked(input string tag);
    in_valid = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_pix_valid"}, pix_valid, 0);
    chk({tag, "_err_ovf"}, err_ovf, 0);
    chk({tag, "_err_short"}, err_short, 0);
    chk({tag, "_err_long"}, err_long, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk({tag, "_in_ready_after"}, in_ready, 1);
  endtask

  initial begin
    do_reset_checked("reset");

    // 1: control packet then a full clean frame.
    start_test();
    add_word(1'b1, 1'b0, 32'h0000_000F);
    add_word(1'b0, 1'b0, 32'h1111_1111);
    add_word(1'b0, 1'b0, 32'h2222_2222);
    add_word(1'b0, 1'b1, 32'h3333_3333);
    add_word(1'b1, 1'b0, 32'h4444_4440);
    for (int k = 0; k < NPIX; k++)
      add_word(1'b0, k == NPIX - 1, {8'h00, 8'hA1, 16'(k)});
    run_stream(-1);
    chk("t1_count", cap.size(), NPIX);
    chk("t1_pixels", frame_bad(0, NPIX, 8'hA1), 0);
    chk("t1_eol", eol_count(), H);
    chk("t1_last_xy", {cap[NPIX-1].x, cap[NPIX-1].y}, {XW'(W - 1), YW'(H - 1)});
    chk("t1_short", n_short, 0);
    chk("t1_long", n_long, 0);
`ifdef VIDEO_SINK_STATUS_EN
    chk("t1_frame_cnt", frame_cnt, 1);
    chk("t1_ctrl_cnt", ctrl_cnt, 1);
`endif

    // 2: backpressure 1-in-3 with upstream 20-on/3-off.
    start_test();
    rdy_div = 3; up_on = 20; up_off = 3;
    add_frame(8'hB2, NPIX);
    run_stream(-1);
    rdy_div = 1; up_on = 1; up_off = 0;
    chk("t2_count", cap.size(), NPIX);
    chk("t2_pixels", frame_bad(0, NPIX, 8'hB2), 0);
    chk("t2_hold", hold_bad, 0);
    chk("t2_ovf", err_ovf, 0);

    // 3: short frame (eop on pixel 25) followed by a good frame.
    start_test();
    add_frame(8'h33, 25);
    add_frame(8'h34, NPIX);
    run_stream(-1);
    chk("t3_count", cap.size(), 25 + NPIX);
    chk("t3_short_px", frame_bad(0, 25, 8'h33), 0);
    chk("t3_next_frame", frame_bad(25, NPIX, 8'h34), 0);
    chk("t3_short", n_short, 1);
    chk("t3_long", n_long, 0);

    // 4: two extra pixels beyond a full frame.
    start_test();
    add_frame(8'h44, NPIX + 2);
    run_stream(-1);
    chk("t4_count", cap.size(), NPIX);
    chk("t4_pixels", frame_bad(0, NPIX, 8'h44), 0);
    chk("t4_long", n_long, 1);
    chk("t4_short", n_short, 0);

    // 5: unknown type-3 packet then a good frame.
    start_test();
    add_word(1'b1, 1'b0, 32'h0000_0003);
    add_word(1'b0, 1'b0, 32'h0000_0055);
    add_word(1'b0, 1'b0, 32'h0000_0066);
    add_word(1'b0, 1'b0, 32'h0000_0077);
    add_word(1'b0, 1'b1, 32'h0000_0088);
    add_frame(8'h55, NPIX);
    run_stream(-1);
    chk("t5_count", cap.size(), NPIX);
    chk("t5_pixels", frame_bad(0, NPIX, 8'h55), 0);
    chk("t5_errs", n_short + n_long, 0);

    // 6: forced writes with pix_ready low; FIFO count after edge k is k-2 from k=3.
    start_test();
    pix_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_sop = 1'b1; in_eop = 1'b0; in_data = 32'h0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      in_sop = 1'b0;
      in_data = 32'(k);
      chk($sformatf("t6_in_ready_%0d", k), in_ready, k < 9);
      chk($sformatf("t6_err_ovf_%0d", k), err_ovf, k >= 11);
      chk($sformatf("t6_pix_valid_%0d", k), pix_valid, k >= 3);
    end
    in_valid = 1'b0;
    do_reset_checked("t6_reset");

    // 7: reset mid-frame, then a full frame must come out clean.
    start_test();
    add_frame(8'h77, NPIX);
    run_stream(20);
    chk("t7_partial", cap.size(), 20);
    do_reset_checked("t7_reset");
    start_test();
    add_frame(8'h78, NPIX);
    run_stream(-1);
    chk("t7_count", cap.size(), NPIX);
    chk("t7_pixels", frame_bad(0, NPIX, 8'h78), 0);
    chk("t7_errs", n_short + n_long, 0);
    chk("t7_ovf", err_ovf, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
